// File: rtl/sipo_capture.sv
// Serial-in parallel-out word capture with an IDLE/COLLECT/HOLD handshake, LSB-first.
// Define SIPO_OVERRUN_EN to add the sticky overrun flag for shifts that arrive while a word is held.
module sipo_capture #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift,
    input  logic             din,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy
`ifdef SIPO_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] sreg_shifted;
    logic [WIDTH-1:0] data_nxt;

    // New bits enter at the MSB, so the first bit received ends up in bit 0.
    assign sreg_shifted = {din, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        data_nxt  = data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = '0;
                    sreg_nxt  = '0;
                end
            end
            COLLECT: begin
                if (start) begin
                    cnt_nxt  = '0;
                    sreg_nxt = '0;
                end else if (shift) begin
                    sreg_nxt = sreg_shifted;
                    // The final bit loads data at the same edge, and the counter wraps so it never reaches WIDTH.
                    if (cnt == LAST) begin
                        data_nxt  = sreg_shifted;
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (start) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = '0;
                    sreg_nxt  = '0;
                end else if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                sreg_nxt  = '0;
            end
        endcase
    end

    assign busy  = (state == COLLECT);
    assign valid = (state == HOLD);

`ifdef SIPO_OVERRUN_EN
    // Sticky until the next start; start wins even when it coincides with a shift in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (start) begin
            overrun <= 1'b0;
        end else if ((state == HOLD) && shift) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sipo_capture.sv
// Self-checking bench for sipo_capture: WIDTH=8 and WIDTH=64 instances share stimulus and are
// compared every cycle against a bit-accumulating reference model, plus directed vectors.
module tb_sipo_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        shift;
    logic        din;
    logic        ack;
    logic [7:0]  data8;
    logic        valid8;
    logic        busy8;
    logic [63:0] data64;
    logic        valid64;
    logic        busy64;
`ifdef SIPO_OVERRUN_EN
    logic        ovr8;
    logic        ovr64;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = 8-bit instance, index 1 = 64-bit instance
    int          wid[2] = '{8, 64};
    int          m_n[2];
    logic [63:0] m_acc[2];
    logic [63:0] m_data[2];
    bit          m_busy[2];
    bit          m_valid[2];
    bit          m_ovr[2];

    typedef struct {
        logic       start;
        logic       shift;
        logic       din;
        logic       ack;
        logic       evalid;
        logic       ebusy;
        logic [7:0] edata;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    sipo_capture #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .shift(shift), .din(din), .ack(ack),
        .data(data8), .valid(valid8), .busy(busy8)
`ifdef SIPO_OVERRUN_EN
        , .overrun(ovr8)
`endif
    );

    sipo_capture #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .start(start), .shift(shift), .din(din), .ack(ack),
        .data(data64), .valid(valid64), .busy(busy64)
`ifdef SIPO_OVERRUN_EN
        , .overrun(ovr64)
`endif
    );

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]     = 0;
            m_acc[i]   = '0;
            m_data[i]  = '0;
            m_busy[i]  = 1'b0;
            m_valid[i] = 1'b0;
            m_ovr[i]   = 1'b0;
        end
    endtask

    // One rising edge of behaviour: bits accumulate by position until wid[i] have arrived.
    task automatic modelStep(input int i);
        if (start) begin
            m_busy[i]  = 1'b1;
            m_valid[i] = 1'b0;
            m_n[i]     = 0;
            m_acc[i]   = '0;
            m_ovr[i]   = 1'b0;
        end else if (m_busy[i]) begin
            if (shift) begin
                m_acc[i] = m_acc[i] | (64'(din) << m_n[i]);
                m_n[i]   = m_n[i] + 1;
                if (m_n[i] == wid[i]) begin
                    m_data[i]  = m_acc[i];
                    m_busy[i]  = 1'b0;
                    m_valid[i] = 1'b1;
                end
            end
        end else if (m_valid[i]) begin
            if (shift) m_ovr[i] = 1'b1;
            if (ack) m_valid[i] = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " valid8"}, 64'(valid8), 64'(m_valid[0]));
        checkOutput({tag, " busy8"}, 64'(busy8), 64'(m_busy[0]));
        checkOutput({tag, " data8"}, 64'(data8), 64'(m_data[0][7:0]));
        checkOutput({tag, " valid64"}, 64'(valid64), 64'(m_valid[1]));
        checkOutput({tag, " busy64"}, 64'(busy64), 64'(m_busy[1]));
        checkOutput({tag, " data64"}, data64, m_data[1]);
`ifdef SIPO_OVERRUN_EN
        checkOutput({tag, " ovr8"}, 64'(ovr8), 64'(m_ovr[0]));
        checkOutput({tag, " ovr64"}, 64'(ovr64), 64'(m_ovr[1]));
`endif
    endtask

    // Drive inputs, advance one rising edge, then sample 1 time unit later.
    task automatic applyStimulus(input string tag, input logic s, input logic sh,
                                 input logic d, input logic a);
        start = s;
        shift = sh;
        din   = d;
        ack   = a;
        @(posedge clk);
        if (rst) begin
            modelStep(0);
            modelStep(1);
        end else begin
            modelReset();
        end
        #1;
        checkModel(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0]  byte4d;
        logic [7:0]  bytea5;
        logic [63:0] w64;
        logic [63:0] pre64;

        byte4d = 8'h4D;
        bytea5 = 8'hA5;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h4D};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h4D};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D};

        rst   = 1'b0;
        start = 1'b0;
        shift = 1'b0;
        din   = 1'b0;
        ack   = 1'b0;
        modelReset();

        $display("[TB] reset for 3 cycles");
        repeat (3) applyStimulus("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("post-reset data8", 64'(data8), 64'h0);
        checkOutput("post-reset valid8", 64'(valid8), 64'h0);
        checkOutput("post-reset busy8", 64'(busy8), 64'h0);

        $display("[TB] table vectors: basic word 0x4D, ack, ignored ack/shift in IDLE");
        for (int k = 0; k < 13; k++) begin
            applyStimulus($sformatf("tbl%0d", k), tbl[k].start, tbl[k].shift, tbl[k].din, tbl[k].ack);
            checkOutput($sformatf("tbl%0d valid", k), 64'(valid8), 64'(tbl[k].evalid));
            checkOutput($sformatf("tbl%0d busy", k), 64'(busy8), 64'(tbl[k].ebusy));
            checkOutput($sformatf("tbl%0d data", k), 64'(data8), 64'(tbl[k].edata));
        end

        $display("[TB] restart mid-word");
        applyStimulus("rs start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) applyStimulus("rs partial", 1'b0, 1'b1, b[0], 1'b0);
        applyStimulus("rs restart", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rs restart busy", 64'(busy8), 64'h1);
        for (int b = 0; b < 8; b++) applyStimulus("rs ones", 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rs data", 64'(data8), 64'hFF);
        checkOutput("rs valid", 64'(valid8), 64'h1);
        applyStimulus("rs start+ack", 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rs start+ack valid", 64'(valid8), 64'h0);
        checkOutput("rs start+ack busy", 64'(busy8), 64'h1);
        checkOutput("rs start+ack data", 64'(data8), 64'hFF);

        $display("[TB] gapped shifts");
        applyStimulus("gap start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            applyStimulus("gap shift", 1'b0, 1'b1, byte4d[b], 1'b0);
            if (b < 7) begin
                checkOutput($sformatf("gap busy after bit %0d", b), 64'(busy8), 64'h1);
                applyStimulus("gap idle", 1'b0, 1'b0, 1'b1, 1'b0);
                checkOutput($sformatf("gap busy in gap %0d", b), 64'(busy8), 64'h1);
            end
        end
        checkOutput("gap data", 64'(data8), 64'h4D);
        checkOutput("gap valid", 64'(valid8), 64'h1);

        $display("[TB] shift while holding a word");
        applyStimulus("ov ack", 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("ov start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) applyStimulus("ov shift", 1'b0, 1'b1, bytea5[b], 1'b0);
        checkOutput("ov data", 64'(data8), 64'hA5);
        applyStimulus("ov hold shift", 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ov held data", 64'(data8), 64'hA5);
        checkOutput("ov held valid", 64'(valid8), 64'h1);
`ifdef SIPO_OVERRUN_EN
        checkOutput("ov flag set", 64'(ovr8), 64'h1);
`endif
        applyStimulus("ov idle", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_OVERRUN_EN
        checkOutput("ov flag sticky", 64'(ovr8), 64'h1);
`endif
        applyStimulus("ov clear", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_OVERRUN_EN
        checkOutput("ov flag cleared", 64'(ovr8), 64'h0);
`endif

        $display("[TB] preload a 64-bit word");
        pre64 = 64'hDEADBEEF_CAFEF00D;
        for (int b = 0; b < 64; b++) applyStimulus("pre64", 1'b0, 1'b1, pre64[b], 1'b0);
        checkOutput("pre64 data", data64, pre64);
        checkOutput("pre64 valid", 64'(valid64), 64'h1);

        $display("[TB] randomized traffic against the model");
        for (int c = 0; c < 400; c++) begin
            applyStimulus("rand", 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
        end

        $display("[TB] asynchronous reset mid-collection");
        applyStimulus("ar start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 30; b++) applyStimulus("ar bits", 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        checkOutput("ar busy before", 64'(busy64), 64'h1);
        rst = 1'b0;
        #1;
        checkOutput("ar busy64", 64'(busy64), 64'h0);
        checkOutput("ar valid64", 64'(valid64), 64'h0);
        checkOutput("ar data64", data64, 64'h0);
        checkOutput("ar data8", 64'(data8), 64'h0);
        modelReset();
        #1;
        rst = 1'b1;
        w64 = 64'h0123456789ABCDEF;
        applyStimulus("ar restart", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ar restart busy64", 64'(busy64), 64'h1);
        for (int b = 0; b < 64; b++) applyStimulus("ar word", 1'b0, 1'b1, w64[b], 1'b0);
        checkOutput("ar word data64", data64, 64'h0123456789ABCDEF);
        checkOutput("ar word valid64", 64'(valid64), 64'h1);
        applyStimulus("ar ack", 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ar ack valid64", 64'(valid64), 64'h0);
        checkOutput("ar ack data64", data64, 64'h0123456789ABCDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_capture.md
SIPO_CAPTURE -- requirements
Module: sipo_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the number of serial bits per word (legal range 2..256).
REQ-002 The block SHALL have port clk, input, 1 bit, as its single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, as its reset: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: clear the capture state and begin collecting a new word.
REQ-005 The block SHALL have port shift, input, 1 bit: din is valid this cycle.
REQ-006 The block SHALL have port din, input, 1 bit: serial data, LSB first.
REQ-007 The block SHALL have port ack, input, 1 bit: the consumer has taken data.
REQ-008 The block SHALL have port data, output, WIDTH bits: the last completed word, registered.
REQ-009 The block SHALL have port valid, output, 1 bit: data holds a completed word not yet acknowledged.
REQ-010 The block SHALL have port busy, output, 1 bit: a collection is in progress.
REQ-011 The block SHALL have port overrun, output, 1 bit, present only when SIPO_OVERRUN_EN is defined.

Function
REQ-012 The block SHALL implement three states, IDLE, COLLECT and HOLD, with busy=1 only in COLLECT and valid=1 only in HOLD.
REQ-013 In IDLE, start=1 SHALL move to COLLECT with the bit counter set to 0 and the shift register cleared, and shift SHALL be ignored.
REQ-014 In COLLECT, each cycle with shift=1 SHALL update the internal shift register to {din, sreg[WIDTH-1:1]} and increment the counter; cycles with shift=0 SHALL leave the state unchanged.
REQ-015 The shift that captures bit WIDTH-1 SHALL, at the same edge, load data with the completed word and move to HOLD, so valid rises 1 cycle after the final shift; the first bit received SHALL end up in data[0].
REQ-016 In HOLD, ack=1 SHALL return to IDLE with valid=0 at the next edge, and data SHALL keep its value.
REQ-017 data SHALL change only on word completion and SHALL otherwise retain the previous word.
REQ-018 start SHALL take priority over shift and ack in every state: in COLLECT it restarts with the counter at 0 and discards partial bits; in HOLD it drops valid and enters COLLECT.
REQ-019 shift in HOLD SHALL be ignored, and the held word SHALL NOT be disturbed.
REQ-020 ack outside HOLD SHALL be ignored.
REQ-021 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH-1 while in COLLECT.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE, counter=0, shift register=0, data=0, valid=0, busy=0 and overrun=0, including mid-COLLECT or in HOLD.
REQ-023 After rst is released, the block SHALL accept start on the first rising edge.

Configuration
REQ-024 With SIPO_OVERRUN_EN defined, overrun SHALL be set on the edge after any shift=1 in HOLD, SHALL remain set until the next start or reset, and SHALL be cleared by start.
REQ-025 Without SIPO_OVERRUN_EN, the overrun port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset, WIDTH=8: hold rst=0 for 3 cycles, then release -> data=0x00, valid=0, busy=0; start next cycle -> busy=1.
REQ-027 Basic word, WIDTH=8: start, then shifts with din 1,0,1,1,0,0,1,0 on consecutive cycles -> valid=1 one cycle after the 8th shift, data=0x4D; ack -> valid=0, data stays 0x4D.
REQ-028 Gapped shifts, WIDTH=8: the same 8 bits with shift deasserted on alternating cycles -> data=0x4D, and busy=1 throughout collection.
REQ-029 Restart mid-word, WIDTH=8: after 5 bits, assert start, then shift 0xFF LSB-first -> data=0xFF; assert start and ack together in HOLD -> valid=0, busy=1.
REQ-030 Asynchronous reset mid-COLLECT, WIDTH=64: pulse rst low between edges after 30 bits -> busy, valid and data are 0 immediately; a new 64-bit word 0x0123456789ABCDEF then captures correctly.
REQ-031 Overrun, with SIPO_OVERRUN_EN: complete a word, shift=1 in HOLD -> overrun=1 and data unchanged; start -> overrun=0. Without the macro, the same stimulus leaves data unchanged.
